// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data memory responder.
package data_mem_responder_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Replace only the byte lanes selected by be, keep the rest of old_w.
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int n = 0; n < BE_W; n++) begin
            if (be[n]) res[8*n +: 8] = new_w[8*n +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word storage with byte-lane writes, synchronous clear and an async read port.
module data_mem_array
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Clear every word on reset; otherwise merge the enabled lanes into the addressed word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[wr_idx_i] <= merge_lanes(mem_q[wr_idx_i], wdata_i, be_i);
        end
    end

    // The controller registers this value, so the read port itself stays combinational.
    assign rdata_o = mem_q[rd_idx_i];

endmodule

// File: rtl/data_mem_responder.sv
// Request/response controller: accepts one request at a time, waits LATENCY
// cycles, commits writes on entry to RESP and acks one cycle later.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              busy_o,
    output logic              ack_o,
    output logic              err_o,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int              IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]      LAT        = 4'(LATENCY);
    localparam logic [ADDR_W-3:0] WORD_LIMIT = (ADDR_W-2)'(DEPTH);

    // Misaligned or beyond the last stored word.
    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || (a[ADDR_W-1:2] >= WORD_LIMIT);
    endfunction

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rerr_q, rerr_d;
    logic              busy_q, busy_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              mem_we;
    logic [BE_W-1:0]   wr_be;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] mem_rdata;

    // Next-state, capture and response logic; the memory write fires on the edge entering RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        be_d    = be_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rerr_d  = rerr_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        wr_be   = be_q;
        wr_idx  = idx_q;
        wr_data = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    be_d    = be_i;
                    idx_d   = addr_i[IDX_W+1:2];
                    wdata_d = wdata_i;
                    rerr_d  = addr_err(addr_i);
                    cnt_d   = LAT;
                    if (LAT == 4'd0) begin
                        // Zero latency: commit straight from the inputs.
                        state_d = ST_RESP;
                        mem_we  = we_i && !addr_err(addr_i);
                        wr_be   = be_i;
                        wr_idx  = addr_i[IDX_W+1:2];
                        wr_data = wdata_i;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                    mem_we  = we_q && !rerr_q;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                ack_d   = 1'b1;
                err_d   = rerr_q;
                if (rerr_q)     rdata_d = '0;
                else if (!we_q) rdata_d = mem_rdata;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Register state and outputs; reset drops any pending request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rerr_q  <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rerr_q  <= rerr_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    data_mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .we_i     (mem_we),
        .be_i     (wr_be),
        .wr_idx_i (wr_idx),
        .wdata_i  (wr_data),
        .rd_idx_i (idx_q),
        .rdata_o  (mem_rdata)
    );

    assign busy_o  = busy_q;
    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;

endmodule
